// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode driver: snapshots per-digit segment codes once per frame
// and scans them with an all-off gap before each digit, with optional leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter logic [7:0]  ZERO_CODE    = 8'hC0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    lz_blank,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);

  localparam int unsigned MaxCycles = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned IdxW      = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [CntW-1:0]         cnt_q;
  logic [8*NUM_DIGITS-1:0] snap_q;
  logic [NUM_DIGITS-1:0]   supp_q;

  logic [NUM_DIGITS-1:0]   supp_new;
  logic                    zero_run;
  logic [7:0]              snap_sel;
  logic [NUM_DIGITS-1:0]   an_sel;

  // Digit i is blanked only if it and every more-significant digit is exactly ZERO_CODE.
  always_comb begin
    supp_new = '0;
    zero_run = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (seg_in[8*i +: 8] == ZERO_CODE);
      supp_new[i] = zero_run;
    end
  end

  always_comb begin
    snap_sel = snap_q[8*int'(idx_q) +: 8];
    an_sel   = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      snap_q      <= '1;
      supp_q      <= '0;
      seg_out     <= 8'hFF;
      an_out      <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state_q)
        StIdle: begin
          seg_out <= 8'hFF;
          an_out  <= '1;
          if (en) begin
            state_q     <= StBlank;
            idx_q       <= '0;
            cnt_q       <= '0;
            snap_q      <= seg_in;
            supp_q      <= supp_new;
            frame_start <= 1'b1;
          end
        end
        StBlank: begin
          if (!en) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
          end else if (cnt_q == BlankLast) begin
            state_q <= StDrive;
            cnt_q   <= '0;
            // Suppressed digits keep the bus dark but still consume their dwell slot.
            if (!supp_q[idx_q]) begin
              seg_out <= snap_sel;
              an_out  <= an_sel;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (!en) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            seg_out <= 8'hFF;
            an_out  <= '1;
          end else if (cnt_q == DwellLast) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            seg_out <= 8'hFF;
            an_out  <= '1;
            if (idx_q == IdxLast) begin
              idx_q       <= '0;
              snap_q      <= seg_in;
              supp_q      <= supp_new;
              frame_start <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
          cnt_q   <= '0;
          seg_out <= 8'hFF;
          an_out  <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with 4 digits, 4-cycle dwell, 2-cycle blank.
module tb_seven_seg_scan_driver;

  localparam int unsigned NumDigits = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        lz_blank;
  logic [31:0] seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_start;

  int checks;
  int failures;

  seven_seg_scan_driver #(
    .NUM_DIGITS  (NumDigits),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2),
    .ZERO_CODE   (8'hC0)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lz_blank   (lz_blank),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting at the sampled frame_start cycle, check cycles 0..n-1 of a frame, then advance
  // one more cycle. Each digit slot is 2 dark cycles followed by 4 driven cycles.
  task automatic check_frame(input string tag, input logic [31:0] pats, input logic [3:0] show,
                             input int n, input int chg_cyc, input logic [31:0] chg_seg,
                             input logic chg_lz);
    logic [3:0] one;
    logic [7:0] seg_exp;
    logic [3:0] an_exp;
    int         d;
    int         ph;
    one = 4'b0001;
    for (int c = 0; c < n; c++) begin
      if (c > 0) tick();
      d  = c / 6;
      ph = c % 6;
      if (ph < 2 || !show[d]) begin
        seg_exp = 8'hFF;
        an_exp  = 4'b1111;
      end else begin
        seg_exp = pats[8*d +: 8];
        an_exp  = ~(one << d);
      end
      check($sformatf("%s c%0d seg", tag, c), {24'd0, seg_out}, {24'd0, seg_exp});
      check($sformatf("%s c%0d an", tag, c), {28'd0, an_out}, {28'd0, an_exp});
      check($sformatf("%s c%0d fs", tag, c), {31'd0, frame_start}, {31'd0, (c == 0)});
      if (c == chg_cyc) begin
        seg_in   = chg_seg;
        lz_blank = chg_lz;
      end
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    lz_blank = 1'b0;
    seg_in   = 32'hF9A4B099;

    // Reset held with en high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst seg", {24'd0, seg_out}, 32'h0000_00FF);
      check("rst an", {28'd0, an_out}, 32'h0000_000F);
      check("rst fs", {31'd0, frame_start}, 32'd0);
    end
    #4 rst_n = 1'b1;
    tick();

    check_frame("f1", 32'hF9A4B099, 4'b1111, 24, -1, 32'h0, 1'b0);
    // Mid-frame input change must not reach the display until the next snapshot.
    check_frame("f2", 32'hF9A4B099, 4'b1111, 24, 9, 32'h80808080, 1'b0);
    check_frame("f3", 32'h80808080, 4'b1111, 24, 0, 32'hC0C0F9C0, 1'b1);
    check_frame("lz1", 32'hC0C0F9C0, 4'b0011, 24, 0, 32'hC0C0C0C0, 1'b1);
    check_frame("lz2", 32'hC0C0C0C0, 4'b0001, 24, 0, 32'h40C0C0C0, 1'b1);
    check_frame("lz3", 32'h40C0C0C0, 4'b1111, 24, 0, 32'h8EA1C6F8, 1'b0);

    // Drop en during the second cycle of digit 2's dwell.
    check_frame("pre_en", 32'h8EA1C6F8, 4'b1111, 15, -1, 32'h0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("en_off %0d seg", i), {24'd0, seg_out}, 32'h0000_00FF);
      check($sformatf("en_off %0d an", i), {28'd0, an_out}, 32'h0000_000F);
      check($sformatf("en_off %0d fs", i), {31'd0, frame_start}, 32'd0);
    end
    seg_in = 32'hF9A4B099;
    en     = 1'b1;
    tick();
    check_frame("restart", 32'hF9A4B099, 4'b1111, 24, -1, 32'h0, 1'b0);

    // Asynchronous reset in the middle of digit 1's dwell.
    check_frame("pre_rst", 32'hF9A4B099, 4'b1111, 10, -1, 32'h0, 1'b0);
    check("pre_rst an driven", {28'd0, an_out}, 32'h0000_000D);
    #2 rst_n = 1'b0;
    #1;
    check("async seg", {24'd0, seg_out}, 32'h0000_00FF);
    check("async an", {28'd0, an_out}, 32'h0000_000F);
    check("async fs", {31'd0, frame_start}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check_frame("post_rst", 32'hF9A4B099, 4'b1111, 24, -1, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
